adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter_pkg.sv | 24 ++
 rtl/adder_arbiter_tag_fifo.sv | 60 ++++++
 rtl/adder_arbiter.sv | 153 +++++++++++++++
 tb/tb_adder_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the round-robin front end of the shared adder:
// default sizes, FSM state encoding, the tag type and an index helper.
package adder_arbiter_pkg;

    localparam int def_n_req = 4;
    localparam int def_width = 4;
    localparam int def_depth = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam int tag_w = $clog2(def_n_req);
    typedef logic [tag_w-1:0] tag_t;

    // Modular add of a requester index and a search offset, both below n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/adder_arbiter_tag_fifo.sv
// Synchronous FIFO of requester tags in grant order. It is used to route adder
// results back to their owners; a push into a full FIFO is taken only alongside a pop.
module adder_arbiter_tag_fifo
    import adder_arbiter_pkg::*;
#(
    parameter int tag_w = 2,
    parameter int depth = def_depth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [tag_w-1:0] push_tag,
    input  logic             pop,
    output logic [tag_w-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int aw = (depth > 1) ? $clog2(depth) : 1;
    localparam int cw = $clog2(depth + 1);

    logic [tag_w-1:0] mem_r [depth];
    logic [aw-1:0]    wr_ptr_r;
    logic [aw-1:0]    rd_ptr_r;
    logic [cw-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == cw'(depth));
    assign empty     = (count_r == '0);
    assign head      = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_tag;
                wr_ptr_r <= (wr_ptr_r == aw'(depth - 1)) ? '0 : wr_ptr_r + aw'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= (rd_ptr_r == aw'(depth - 1)) ? '0 : rd_ptr_r + aw'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + cw'(1);
                2'b01:   count_r <= count_r - cw'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one flow-controlled adder among n_req requesters;
// results are steered back to their owners through a FIFO of grant tags.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int n_req = def_n_req,
    parameter int width = def_width,
    parameter int depth = def_depth
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [n_req-1:0]       req_vld,
    output logic [n_req-1:0]       req_rdy,
    input  logic [n_req*width-1:0] req_a,
    input  logic [n_req*width-1:0] req_b,
    output logic                   a_vld,
    output logic                   b_vld,
    input  logic                   a_rdy,
    input  logic                   b_rdy,
    output logic [width-1:0]       a_data,
    output logic [width-1:0]       b_data,
    input  logic                   sum_vld,
    output logic                   sum_rdy,
    input  logic [width:0]         sum_data,
    output logic [n_req-1:0]       rsp_vld,
    input  logic [n_req-1:0]       rsp_rdy,
    output logic [width:0]         rsp_data
);

    localparam int tw = $clog2(n_req);

    state_t           state_r;
    logic [tw-1:0]    rr_ptr_r;
    logic             a_vld_r;
    logic             b_vld_r;
    logic [width-1:0] a_hold_r;
    logic [width-1:0] b_hold_r;

    logic             grant_found_s;
    logic [tw-1:0]    grant_idx_s;
    logic             grant_s;
    logic             a_hs_s;
    logic             b_hs_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [tw-1:0]    fifo_head_s;
    logic             fifo_pop_s;

    assign a_vld    = a_vld_r;
    assign b_vld    = b_vld_r;
    assign a_data   = a_hold_r;
    assign b_data   = b_hold_r;
    assign rsp_data = sum_data;
    assign a_hs_s   = a_vld_r & a_rdy;
    assign b_hs_s   = b_vld_r & b_rdy;

    // Grant is gated by rst_n so req_rdy stays low while reset is held.
    assign grant_s  = rst_n & (state_r == IDLE) & grant_found_s & ~fifo_full_s;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int i = 0; i < n_req; i++) begin
            if (!grant_found_s && req_vld[wrap_idx(int'(rr_ptr_r), i, n_req)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = tw'(wrap_idx(int'(rr_ptr_r), i, n_req));
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot accept toward the granted requester.
    always_comb begin
        req_rdy = '0;
        if (grant_s) begin
            req_rdy[grant_idx_s] = 1'b1;
        end else begin
            req_rdy = '0;
        end
    end

    // Route the adder result to the requester at the tag FIFO head.
    always_comb begin
        rsp_vld = '0;
        sum_rdy = 1'b0;
        if (!fifo_empty_s) begin
            rsp_vld[fifo_head_s] = sum_vld;
            sum_rdy              = rsp_rdy[fifo_head_s];
        end else begin
            rsp_vld = '0;
            sum_rdy = 1'b0;
        end
    end

    assign fifo_pop_s = sum_vld & sum_rdy;

    // Arbitration FSM; a_vld_r/b_vld_r are the inverted per-operand done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            a_vld_r  <= 1'b0;
            b_vld_r  <= 1'b0;
            a_hold_r <= '0;
            b_hold_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        a_hold_r <= req_a[int'(grant_idx_s)*width +: width];
                        b_hold_r <= req_b[int'(grant_idx_s)*width +: width];
                        a_vld_r  <= 1'b1;
                        b_vld_r  <= 1'b1;
                        rr_ptr_r <= (grant_idx_s == tw'(n_req - 1)) ? '0 : grant_idx_s + tw'(1);
                        state_r  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if ((~a_vld_r | a_rdy) & (~b_vld_r | b_rdy)) begin
                        a_vld_r <= 1'b0;
                        b_vld_r <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        if (a_hs_s) a_vld_r <= 1'b0;
                        if (b_hs_s) b_vld_r <= 1'b0;
                    end
                end
                default: begin
                    a_vld_r <= 1'b0;
                    b_vld_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    adder_arbiter_tag_fifo #(
        .tag_w (tw),
        .depth (depth)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (grant_s),
        .push_tag (grant_idx_s),
        .pop      (fifo_pop_s),
        .head     (fifo_head_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s)
    );

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: a behavioural flow-controlled adder with a 3-deep
// result queue, per-requester expected-result queues and directed sequences.
module tb_adder_arbiter;

    localparam int N = 4;
    localparam int W = 4;
    localparam int D = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_vld;
    logic [N-1:0]     req_rdy;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             a_vld, b_vld, a_rdy, b_rdy;
    logic [W-1:0]     a_data, b_data;
    logic             sum_vld, sum_rdy;
    logic [W:0]       sum_data;
    logic [N-1:0]     rsp_vld;
    logic [N-1:0]     rsp_rdy;
    logic [W:0]       rsp_data;

    always #5 clk = ~clk;

    adder_arbiter #(.n_req(N), .width(W), .depth(D)) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_a(req_a), .req_b(req_b), .a_vld(a_vld), .b_vld(b_vld),
        .a_rdy(a_rdy), .b_rdy(b_rdy), .a_data(a_data), .b_data(b_data),
        .sum_vld(sum_vld), .sum_rdy(sum_rdy), .sum_data(sum_data),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data)
    );

    // Behavioural adder: one-entry operand registers, 3-entry ordered result queue.
    logic         a_stall = 1'b0, b_stall = 1'b0, s_stall = 1'b0;
    logic         ad_a_full, ad_b_full;
    logic [W-1:0] ad_a_op, ad_b_op;
    logic [W:0]   ad_res [3];
    logic [1:0]   ad_cnt;
    logic         ad_pop, ad_push;

    assign a_rdy    = ~ad_a_full & ~a_stall;
    assign b_rdy    = ~ad_b_full & ~b_stall;
    assign sum_vld  = (ad_cnt != 2'd0) & ~s_stall;
    assign sum_data = ad_res[0];
    assign ad_pop   = sum_vld & sum_rdy;
    assign ad_push  = ad_a_full & ad_b_full & (ad_cnt != 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ad_a_full <= 1'b0; ad_b_full <= 1'b0;
            ad_a_op <= '0; ad_b_op <= '0; ad_cnt <= 2'd0;
            for (int i = 0; i < 3; i++) ad_res[i] <= '0;
        end else begin
            if (a_vld && a_rdy) begin ad_a_full <= 1'b1; ad_a_op <= a_data; end
            else if (ad_push) ad_a_full <= 1'b0;
            if (b_vld && b_rdy) begin ad_b_full <= 1'b1; ad_b_op <= b_data; end
            else if (ad_push) ad_b_full <= 1'b0;
            if (ad_pop) begin ad_res[0] <= ad_res[1]; ad_res[1] <= ad_res[2]; end
            if (ad_push) ad_res[ad_cnt - {1'b0, ad_pop}] <= {1'b0, ad_a_op} + {1'b0, ad_b_op};
            ad_cnt <= ad_cnt - {1'b0, ad_pop} + {1'b0, ad_push};
        end
    end

    int         n_cmp = 0;
    int         n_mis = 0;
    logic [W:0] exp_q [N][$];
    int         gl[$];
    logic [W:0] rl[$];
    int         gcnt [N];
    int         a_hs = 0, b_hs = 0;
    logic       prev_a_wait = 1'b0, prev_b_wait = 1'b0;
    logic [W-1:0] prev_a_data, prev_b_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int r = 0; r < N; r++) s += exp_q[r].size();
        return s;
    endfunction

    // Scoreboard: sampled mid-cycle, i.e. the values that the next posedge commits.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) exp_q[r].delete();
            prev_a_wait = 1'b0;
            prev_b_wait = 1'b0;
        end else begin
            if (req_rdy != '0) begin
                chk("rdy_onehot", 32'($countones(req_rdy)), 32'd1);
                for (int r = 0; r < N; r++) begin
                    if (req_rdy[r]) begin
                        exp_q[r].push_back({1'b0, req_a[r*W +: W]} + {1'b0, req_b[r*W +: W]});
                        gl.push_back(r);
                        gcnt[r]++;
                    end
                end
            end
            for (int r = 0; r < N; r++) begin
                if (rsp_vld[r] && rsp_rdy[r]) begin
                    rl.push_back(rsp_data);
                    if (exp_q[r].size() == 0) chk($sformatf("rsp%0d_unexpected", r), 32'(exp_q[r].size()), 32'd1);
                    else chk($sformatf("rsp%0d_data", r), 32'(rsp_data), 32'(exp_q[r].pop_front()));
                end
            end
            if (prev_a_wait) chk("a_hold", {27'd0, a_vld, a_data}, {27'd0, 1'b1, prev_a_data});
            if (prev_b_wait) chk("b_hold", {27'd0, b_vld, b_data}, {27'd0, 1'b1, prev_b_data});
            if (a_vld && a_rdy) a_hs++;
            if (b_vld && b_rdy) b_hs++;
            prev_a_wait = a_vld & ~a_rdy;
            prev_b_wait = b_vld & ~b_rdy;
            prev_a_data = a_data;
            prev_b_data = b_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int r = 0; r < N; r++) begin
            req_a[r*W +: W] = a;
            req_b[r*W +: W] = b;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc();
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 300 && pending() != 0; i++) cyc();
        chk(nm, 32'(pending()), 32'd0);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_req_rdy"}, 32'(req_rdy), 32'd0);
        chk({nm, "_a_vld"},   32'(a_vld),   32'd0);
        chk({nm, "_b_vld"},   32'(b_vld),   32'd0);
        chk({nm, "_sum_rdy"}, 32'(sum_rdy), 32'd0);
        chk({nm, "_rsp_vld"}, 32'(rsp_vld), 32'd0);
        chk({nm, "_a_data"},  32'(a_data),  32'd0);
        chk({nm, "_b_data"},  32'(b_data),  32'd0);
    endtask

    typedef struct {
        logic [N-1:0] vld;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [N-1:0] exp_rdy;
        logic [W:0]   exp_sum;
    } vec_t;

    vec_t tbl [8];
    int   exp_g [5] = '{0, 1, 2, 3, 0};
    logic [W:0] exp_s [4] = '{5'h0F, 5'h10, 5'h11, 5'h12};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Hand-computed: rr_ptr starts at 0 and advances past each grant.
        tbl[0] = '{4'b0001, 4'h3, 4'h4, 4'b0001, 5'h07};
        tbl[1] = '{4'b1111, 4'h1, 4'hF, 4'b0010, 5'h10};
        tbl[2] = '{4'b1001, 4'hF, 4'hF, 4'b1000, 5'h1E};
        tbl[3] = '{4'b0110, 4'h0, 4'h0, 4'b0010, 5'h00};
        tbl[4] = '{4'b0011, 4'h8, 4'h8, 4'b0001, 5'h10};
        tbl[5] = '{4'b0100, 4'h7, 4'h9, 4'b0100, 5'h10};
        tbl[6] = '{4'b1000, 4'hA, 4'h5, 4'b1000, 5'h0F};
        tbl[7] = '{4'b0000, 4'h2, 4'h2, 4'b0000, 5'h04};
        for (int r = 0; r < N; r++) gcnt[r] = 0;

        rst_n = 1'b0; req_vld = '0; req_a = '0; req_b = '0; rsp_rdy = '1;
        repeat (2) @(posedge clk);
        #1 req_vld = '1; set_ops(4'h5, 4'h6);
        #1 chk_reset_outs("reset");
        req_vld = '0;
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Table-driven single operations.
        for (int v = 0; v < 8; v++) begin
            cyc();
            req_vld = tbl[v].vld;
            set_ops(tbl[v].a, tbl[v].b);
            #1 chk($sformatf("vec%0d_req_rdy", v), 32'(req_rdy), 32'(tbl[v].exp_rdy));
            cyc();
            req_vld = '0;
            #1;
            if (tbl[v].exp_rdy != '0) begin
                chk($sformatf("vec%0d_ab_vld", v), {30'd0, a_vld, b_vld}, 32'd3);
                chk($sformatf("vec%0d_a_data", v), 32'(a_data), 32'(tbl[v].a));
                chk($sformatf("vec%0d_b_data", v), 32'(b_data), 32'(tbl[v].b));
                for (int i = 0; i < 20 && rsp_vld == '0; i++) begin cyc(); #1; end
                chk($sformatf("vec%0d_rsp_vld", v), 32'(rsp_vld), 32'(tbl[v].exp_rdy));
                chk($sformatf("vec%0d_rsp_data", v), 32'(rsp_data), 32'(tbl[v].exp_sum));
            end else begin
                chk($sformatf("vec%0d_idle", v), {30'd0, a_vld, b_vld}, 32'd0);
            end
            cyc();
        end

        // All four valid from reset: grants 0,1,2,3,0.
        do_reset();
        gl.delete(); rl.delete();
        for (int r = 0; r < N; r++) begin
            req_a[r*W +: W] = W'(r);
            req_b[r*W +: W] = 4'hF;
        end
        req_vld = '1;
        for (int i = 0; i < 40 && gl.size() < 5; i++) cyc();
        req_vld = '0;
        chk("rr_grants", 32'(gl.size()), 32'd5);
        for (int k = 0; k < 5; k++) if (k < gl.size()) chk($sformatf("rr_order%0d", k), 32'(gl[k]), 32'(exp_g[k]));
        wait_drain("rr_drain");
        for (int k = 0; k < 4; k++) if (k < rl.size()) chk($sformatf("rr_sum%0d", k), 32'(rl[k]), 32'(exp_s[k]));

        // Responses blocked: grants stop at FIFO depth, then drain in order.
        gl.delete(); rl.delete();
        rsp_rdy = '0;
        req_vld = '1;
        repeat (30) cyc();
        #1;
        chk("full_grants", 32'(gl.size()), 32'd4);
        chk("full_req_rdy", 32'(req_rdy), 32'd0);
        req_vld = '0;
        rsp_rdy = '1;
        wait_drain("full_drain");
        chk("full_rsp_cnt", 32'(rl.size()), 32'd4);

        // b stalled for 5 ISSUE cycles.
        cyc();
        a_hs = 0; b_hs = 0;
        b_stall = 1'b1;
        req_vld = 4'b0001;
        set_ops(4'h5, 4'h6);
        cyc();
        req_vld = '0;
        #1 chk("stall_first", {30'd0, a_vld, b_vld}, 32'd3);
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            chk($sformatf("stall%0d_vld", k), {30'd0, a_vld, b_vld}, 32'd1);
            chk($sformatf("stall%0d_b_data", k), 32'(b_data), 32'd6);
        end
        cyc();
        b_stall = 1'b0;
        wait_drain("stall_drain");
        chk("stall_a_once", 32'(a_hs), 32'd1);
        chk("stall_b_once", 32'(b_hs), 32'd1);

        // Reset pulse mid-ISSUE after a grant to requester 2 (rr_ptr would be 3).
        do_reset();
        b_stall = 1'b1;
        req_vld = 4'b0100;
        set_ops(4'h5, 4'h6);
        cyc();
        req_vld = '0;
        cyc();
        #2;
        req_vld = '1;
        rst_n = 1'b0;
        #1 chk_reset_outs("midrst");
        req_vld = '0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        b_stall = 1'b0;
        gl.delete();
        cyc();
        req_vld = '1;
        for (int i = 0; i < 10 && gl.size() == 0; i++) cyc();
        req_vld = '0;
        chk("midrst_grant_seen", 32'(gl.size() > 0), 32'd1);
        if (gl.size() > 0) chk("midrst_first_grant", 32'(gl[0]), 32'd0);
        wait_drain("midrst_drain");

        // Random traffic with stalls on every channel.
        gl.delete();
        for (int r = 0; r < N; r++) gcnt[r] = 0;
        for (int c = 0; c < 6000 && gl.size() < 200; c++) begin
            cyc();
            req_vld = N'($urandom);
            rsp_rdy = N'($urandom);
            a_stall = ($urandom_range(0, 3) == 0);
            b_stall = ($urandom_range(0, 3) == 0);
            s_stall = ($urandom_range(0, 3) == 0);
            req_a   = (N*W)'($urandom);
            req_b   = (N*W)'($urandom);
        end
        req_vld = '0; rsp_rdy = '1;
        a_stall = 1'b0; b_stall = 1'b0; s_stall = 1'b0;
        chk("rand_ops", 32'(gl.size() >= 200), 32'd1);
        wait_drain("rand_drain");
        for (int r = 0; r < N; r++) chk($sformatf("rand_served%0d", r), 32'(gcnt[r] > 0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
